// File: rtl/mips_alu_unit.sv
// rtl/mips_alu_unit.sv - MIPS execute ALU with iterative mul/div and HI/LO registers
// Define MIPS_ALU_DIV_EN to build the restoring divider and DIV state.

module mips_alu_unit #(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             valid_i,
    input  logic [1:0]       ALUop_i,
    input  logic [5:0]       funct_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             ovf_o,
    output logic             div0_o,
    output logic             illegal_o
);

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;
    localparam logic [5:0] F_SLLV  = 6'b000100;
    localparam logic [5:0] F_SRLV  = 6'b000110;
    localparam logic [5:0] F_SRAV  = 6'b000111;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
`ifdef MIPS_ALU_DIV_EN
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_MUL} state_t;
`endif

    state_t               state;
    logic [WIDTH-1:0]     hi, lo;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     opnd;
    logic                 neg;
    logic [SHW-1:0]       cnt;
    logic                 last;

    logic [WIDTH-1:0]     sum, diff, sra_res, mag_a, mag_b;
    logic                 add_ovf, sub_ovf;
    logic [WIDTH-1:0]     c_res;
    logic                 c_ovf, c_ill, c_mthi, c_mtlo, c_mul, c_signed;

    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next, mul_final;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
        return (sgn && x[WIDTH-1]) ? -x : x;
    endfunction

    assign sum     = a_i + b_i;
    assign diff    = a_i - b_i;
    assign sra_res = $signed(b_i) >>> a_i[SHW-1:0];
    assign add_ovf = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
    assign sub_ovf = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1]);
    assign mag_a   = mag(a_i, c_signed);
    assign mag_b   = mag(b_i, c_signed);
    assign ready_o = (state == S_IDLE);
    assign last    = (cnt == SHW'(WIDTH - 1));

    // Shift-add step: acc holds {partial product, remaining multiplier bits}.
    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    assign mul_next  = {mul_sum, acc[WIDTH-1:1]};
    assign mul_final = neg ? -mul_next : mul_next;

`ifdef MIPS_ALU_DIV_EN
    logic             c_div, rneg, div0_q;
    logic [WIDTH:0]   div_sh, div_sub;
    logic             div_ge;
    logic [WIDTH-1:0] rem_n, quo_n, quo_fin, rem_fin;

    // Restoring step: acc holds {partial remainder, dividend bits / quotient}.
    assign div_sh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_sub = div_sh - {1'b0, opnd};
    assign div_ge  = (div_sh >= {1'b0, opnd});
    assign rem_n   = div_ge ? div_sub[WIDTH-1:0] : div_sh[WIDTH-1:0];
    assign quo_n   = {acc[WIDTH-2:0], div_ge};
    assign quo_fin = neg  ? -quo_n : quo_n;
    assign rem_fin = rneg ? -rem_n : rem_n;
    assign div0_o  = div0_q;
`else
    assign div0_o  = 1'b0;
`endif

    always_comb begin
        c_res    = '0;
        c_ovf    = 1'b0;
        c_ill    = 1'b0;
        c_mthi   = 1'b0;
        c_mtlo   = 1'b0;
        c_mul    = 1'b0;
        c_signed = 1'b0;
`ifdef MIPS_ALU_DIV_EN
        c_div    = 1'b0;
`endif
        case (ALUop_i)
            2'b00: begin c_res = sum;  c_ovf = add_ovf; end
            2'b01: begin c_res = diff; c_ovf = sub_ovf; end
            2'b10: begin
                case (funct_i)
                    F_ADD:   begin c_res = sum;  c_ovf = add_ovf; end
                    F_ADDU:  c_res = sum;
                    F_SUB:   begin c_res = diff; c_ovf = sub_ovf; end
                    F_SUBU:  c_res = diff;
                    F_AND:   c_res = a_i & b_i;
                    F_OR:    c_res = a_i | b_i;
                    F_XOR:   c_res = a_i ^ b_i;
                    F_NOR:   c_res = ~(a_i | b_i);
                    F_SLT:   c_res = {{(WIDTH-1){1'b0}}, $signed(a_i) < $signed(b_i)};
                    F_SLTU:  c_res = {{(WIDTH-1){1'b0}}, a_i < b_i};
                    F_SLLV:  c_res = b_i << a_i[SHW-1:0];
                    F_SRLV:  c_res = b_i >> a_i[SHW-1:0];
                    F_SRAV:  c_res = sra_res;
                    F_MFHI:  c_res = hi;
                    F_MFLO:  c_res = lo;
                    F_MTHI:  begin c_res = a_i; c_mthi = 1'b1; end
                    F_MTLO:  begin c_res = a_i; c_mtlo = 1'b1; end
                    F_MULT:  begin c_mul = 1'b1; c_signed = 1'b1; end
                    F_MULTU: c_mul = 1'b1;
`ifdef MIPS_ALU_DIV_EN
                    F_DIV:   begin c_div = 1'b1; c_signed = 1'b1; end
                    F_DIVU:  c_div = 1'b1;
`endif
                    default: c_ill = 1'b1;
                endcase
            end
            default: c_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state     <= S_IDLE;
            hi        <= '0;
            lo        <= '0;
            acc       <= '0;
            opnd      <= '0;
            neg       <= 1'b0;
            cnt       <= '0;
            valid_o   <= 1'b0;
            result_o  <= '0;
            zero_o    <= 1'b0;
            ovf_o     <= 1'b0;
            illegal_o <= 1'b0;
`ifdef MIPS_ALU_DIV_EN
            rneg      <= 1'b0;
            div0_q    <= 1'b0;
`endif
        end else begin
            valid_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (valid_i) begin
                        if (c_mul) begin
                            state <= S_MUL;
                            acc   <= {{WIDTH{1'b0}}, mag_b};
                            opnd  <= mag_a;
                            neg   <= c_signed && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                            cnt   <= '0;
`ifdef MIPS_ALU_DIV_EN
                        end else if (c_div && (b_i == '0)) begin
                            hi        <= a_i;
                            lo        <= '1;
                            result_o  <= '1;
                            zero_o    <= 1'b0;
                            ovf_o     <= 1'b0;
                            illegal_o <= 1'b0;
                            div0_q    <= 1'b1;
                            valid_o   <= 1'b1;
                        end else if (c_div) begin
                            state <= S_DIV;
                            acc   <= {{WIDTH{1'b0}}, mag_a};
                            opnd  <= mag_b;
                            neg   <= c_signed && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                            rneg  <= c_signed && a_i[WIDTH-1];
                            cnt   <= '0;
`endif
                        end else begin
                            result_o  <= c_res;
                            zero_o    <= (c_res == '0);
                            ovf_o     <= c_ovf;
                            illegal_o <= c_ill;
                            valid_o   <= 1'b1;
`ifdef MIPS_ALU_DIV_EN
                            div0_q    <= 1'b0;
`endif
                            if (c_mthi) hi <= a_i;
                            if (c_mtlo) lo <= a_i;
                        end
                    end
                end
                S_MUL: begin
                    acc <= mul_next;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        state     <= S_IDLE;
                        hi        <= mul_final[2*WIDTH-1:WIDTH];
                        lo        <= mul_final[WIDTH-1:0];
                        result_o  <= mul_final[WIDTH-1:0];
                        zero_o    <= (mul_final[WIDTH-1:0] == '0);
                        ovf_o     <= 1'b0;
                        illegal_o <= 1'b0;
                        valid_o   <= 1'b1;
`ifdef MIPS_ALU_DIV_EN
                        div0_q    <= 1'b0;
`endif
                    end
                end
`ifdef MIPS_ALU_DIV_EN
                S_DIV: begin
                    acc <= {rem_n, quo_n};
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        state     <= S_IDLE;
                        hi        <= rem_fin;
                        lo        <= quo_fin;
                        result_o  <= quo_fin;
                        zero_o    <= (quo_fin == '0);
                        ovf_o     <= 1'b0;
                        illegal_o <= 1'b0;
                        div0_q    <= 1'b0;
                        valid_o   <= 1'b1;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_alu_unit.sv
// tb/tb_mips_alu_unit.sv - scoreboard bench for mips_alu_unit against an arithmetic reference model

module tb_mips_alu_unit;

    logic        clk = 1'b0;
    logic        rstn;
    logic        valid_i;
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic [31:0] a, b;
    logic        ready_o, valid_o, zero_o, ovf_o, div0_o, illegal_o;
    logic [31:0] result_o;

    mips_alu_unit #(.WIDTH(32)) dut (
        .clk_i(clk), .rstn_i(rstn), .valid_i(valid_i), .ALUop_i(aluop),
        .funct_i(funct), .a_i(a), .b_i(b), .ready_o(ready_o), .valid_o(valid_o),
        .result_o(result_o), .zero_o(zero_o), .ovf_o(ovf_o), .div0_o(div0_o),
        .illegal_o(illegal_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flags;
        int          due;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] m_hi = '0, m_lo = '0;
    int          n_checks = 0, n_pass = 0;

    logic [5:0] ftab [23] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                              6'h2a, 6'h2b, 6'h04, 6'h06, 6'h07, 6'h10, 6'h12, 6'h11,
                              6'h13, 6'h18, 6'h19, 6'h1a, 6'h1b, 6'h3f, 6'h05};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: results from plain 64-bit arithmetic, HI/LO as architectural state.
    task automatic model(input logic [1:0] op, input logic [5:0] f, input logic [31:0] x,
                         input logic [31:0] y, output exp_t e);
        longint      sx, sy, r;
        logic [63:0] p, ux, uy;
        logic        ov = 1'b0, d0 = 1'b0, il = 1'b0;
        int          lat = 1;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'b0, x};
        uy = {32'b0, y};
        r  = 0;
        if (op == 2'b00) begin
            r = sx + sy; ov = (r != longint'($signed(r[31:0])));
        end else if (op == 2'b01) begin
            r = sx - sy; ov = (r != longint'($signed(r[31:0])));
        end else if (op == 2'b11) begin
            il = 1'b1;
        end else begin
            case (f)
                6'h20: begin r = sx + sy; ov = (r != longint'($signed(r[31:0]))); end
                6'h21: r = sx + sy;
                6'h22: begin r = sx - sy; ov = (r != longint'($signed(r[31:0]))); end
                6'h23: r = sx - sy;
                6'h24: r = longint'(x & y);
                6'h25: r = longint'(x | y);
                6'h26: r = longint'(x ^ y);
                6'h27: r = longint'(~(x | y));
                6'h2a: r = (sx < sy) ? 1 : 0;
                6'h2b: r = (ux < uy) ? 1 : 0;
                6'h04: r = longint'(y << x[4:0]);
                6'h06: r = longint'(y >> x[4:0]);
                6'h07: r = sy >>> x[4:0];
                6'h10: r = longint'(m_hi);
                6'h12: r = longint'(m_lo);
                6'h11: begin r = longint'(x); m_hi = x; end
                6'h13: begin r = longint'(x); m_lo = x; end
                6'h18, 6'h19: begin
                    p = (f == 6'h18) ? 64'(sx * sy) : ux * uy;
                    m_hi = p[63:32]; m_lo = p[31:0]; r = longint'(p); lat = 33;
                end
`ifdef MIPS_ALU_DIV_EN
                6'h1a, 6'h1b: begin
                    if (y == 0) begin
                        m_hi = x; m_lo = '1; d0 = 1'b1;
                    end else if (f == 6'h1a) begin
                        p = 64'(sx / sy); m_lo = p[31:0];
                        p = 64'(sx % sy); m_hi = p[31:0]; lat = 33;
                    end else begin
                        p = ux / uy; m_lo = p[31:0];
                        p = ux % uy; m_hi = p[31:0]; lat = 33;
                    end
                    r = longint'(m_lo);
                end
`endif
                default: il = 1'b1;
            endcase
        end
        e.res   = il ? 32'h0 : r[31:0];
        e.flags = {(e.res == 32'h0), ov, d0, il};
        e.due   = cyc + lat;
    endtask

    task automatic issue(input logic [1:0] op, input logic [5:0] f, input logic [31:0] x,
                         input logic [31:0] y, input bit track);
        int   w = 0;
        exp_t e;
        @(negedge clk);
        while (!ready_o && w < 100) begin
            valid_i = 1'($urandom);
            aluop = 2'($urandom); funct = 6'($urandom); a = $urandom; b = $urandom;
            w++;
            @(negedge clk);
        end
        if (!ready_o) chk("ready_timeout", 64'(ready_o), 64'd1);
        valid_i = 1'b1; aluop = op; funct = f; a = x; b = y;
        model(op, f, x, y, e);
        if (track) sbq.push_back(e);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        valid_i = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    function automatic logic [31:0] rv();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h7FFF_FFFF;
            4: return 32'h1;
            5: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rstn && valid_o) begin
            if (sbq.size() == 0) begin
                chk("unexpected_valid", 64'd1, 64'd0);
            end else begin
                e = sbq.pop_front();
                chk("result", 64'(result_o), 64'(e.res));
                chk("flags_zodi", 64'({zero_o, ovf_o, div0_o, illegal_o}), 64'(e.flags));
                chk("latency_cycle", 64'(cyc), 64'(e.due));
            end
        end
    end

    initial begin
        rstn = 1'b0; valid_i = 1'b0; aluop = '0; funct = '0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_ready", 64'(ready_o), 64'd1);
        chk("reset_outs", 64'({valid_o, zero_o, ovf_o, div0_o, illegal_o}), 64'd0);
        chk("reset_result", 64'(result_o), 64'd0);
        @(negedge clk);
        rstn = 1'b1;

        issue(2'b00, 6'h00, 32'h7FFF_FFFF, 32'h1, 1);
        issue(2'b10, 6'h21, 32'h7FFF_FFFF, 32'h1, 1);
        issue(2'b01, 6'h00, 32'h8000_0000, 32'h1, 1);
        foreach (ftab[i]) if (i >= 4 && i <= 9 && i != 6)
            issue(2'b10, ftab[i], 32'hFFFF_FFF0, 32'h0000_000F, 1);
        issue(2'b10, 6'h18, 32'hFFFF_FFFD, 32'd7, 1);
        issue(2'b10, 6'h10, 32'h0, 32'h0, 1);
        issue(2'b10, 6'h12, 32'h0, 32'h0, 1);
        issue(2'b10, 6'h1a, 32'hFFFF_FFF9, 32'd2, 1);
        issue(2'b10, 6'h10, 32'h0, 32'h0, 1);
        issue(2'b10, 6'h1a, 32'd5, 32'd0, 1);
        issue(2'b10, 6'h10, 32'h0, 32'h0, 1);
        issue(2'b10, 6'h1a, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        issue(2'b10, 6'h10, 32'h0, 32'h0, 1);
        issue(2'b10, 6'h1b, 32'hFFFF_FFF9, 32'd2, 1);
        issue(2'b10, 6'h12, 32'h0, 32'h0, 1);

        // multu cut short by reset: no strobe may appear, HI/LO return to zero.
        issue(2'b10, 6'h19, 32'hDEAD_BEEF, 32'h1234_5678, 0);
        idle(10);
        rstn = 1'b0;
        m_hi = '0; m_lo = '0;
        idle(2);
        rstn = 1'b1;
        #1;
        chk("ready_after_reset", 64'(ready_o), 64'd1);
        issue(2'b10, 6'h10, 32'h0, 32'h0, 1);
        issue(2'b10, 6'h12, 32'h0, 32'h0, 1);

        for (int i = 0; i < 300; i++) begin
            int          s;
            logic [1:0]  op;
            logic [5:0]  f;
            s  = $urandom_range(0, 19);
            op = 2'b10;
            f  = ftab[$urandom_range(0, 22)];
            if (s == 0) op = 2'b00;
            else if (s == 1) op = 2'b01;
            else if (s == 2) op = 2'b11;
            else if (s == 3) f = 6'($urandom);
            issue(op, f, rv(), rv(), 1);
            if ($urandom_range(0, 9) == 0) idle($urandom_range(1, 3));
        end
        idle(1);

        for (int w = 0; w < 100 && sbq.size() > 0; w++) @(negedge clk);
        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
